// File: rtl/serial_dequantizer_pkg.sv
// rtl/serial_dequantizer_pkg.sv - shared types and widths for the serial dequantizer
package serial_dequantizer_pkg;

    localparam int WORD_W = 32;
    localparam int LOC_W  = 6;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        OUT
    } state_t;

    // Headers above 32 name a bit that does not exist; clamp to the MSB.
    function automatic logic [LOC_W-1:0] sat_loc(input logic [LOC_W-1:0] loc);
        return (loc > LOC_W'(WORD_W)) ? LOC_W'(WORD_W) : loc;
    endfunction

endpackage

// File: rtl/serial_dequantizer_word_rebuild.sv
// rtl/serial_dequantizer_word_rebuild.sv - combinational leading-one plus mantissa word assembly
module word_rebuild
    import serial_dequantizer_pkg::*;
(
    input  logic [LOC_W-1:0]  loc_i,
    input  logic [LOC_W-1:0]  n_i,
    input  logic [WORD_W-1:0] mant_i,
    output logic [WORD_W-1:0] word_o
);

    logic [WORD_W-1:0] lead_sh;
    logic [WORD_W-1:0] mant_sh;

    // n_i never exceeds loc_i-1, so mant_sh cannot wrap below zero.
    always_comb begin
        lead_sh = WORD_W'(loc_i) - WORD_W'(1);
        mant_sh = WORD_W'(loc_i) - WORD_W'(1) - WORD_W'(n_i);
        word_o  = '0;
        if (loc_i != '0) begin
            word_o = (WORD_W'(1) << lead_sh) | (mant_i << mant_sh);
        end
    end

endmodule

// File: rtl/serial_dequantizer.sv
// rtl/serial_dequantizer.sv - rebuilds 32-bit words from a leading-one header and serial mantissa bits
module serial_dequantizer
    import serial_dequantizer_pkg::*;
#(
    parameter int MANT_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LOC_W-1:0]  locationOfOne,
    input  logic              hdrValid,
    output logic              hdrReady,
    input  logic              bitIn,
    input  logic              bitValid,
    output logic [WORD_W-1:0] outputWord,
    output logic              outValid,
    input  logic              outReady,
    output logic              hdrErr
);

    localparam logic [LOC_W-1:0] MANT_N = LOC_W'(MANT_BITS);

    state_t            state_q, state_d;
    logic [LOC_W-1:0]  loc_q, loc_d;
    logic [LOC_W-1:0]  n_q, n_d;
    logic [LOC_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] mant_q, mant_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic [LOC_W-1:0]  hdr_loc;
    logic [LOC_W-1:0]  hdr_m1;
    logic [LOC_W-1:0]  hdr_n;
    logic [LOC_W-1:0]  cnt_inc;
    logic [WORD_W-1:0] mant_shift;
    logic [LOC_W-1:0]  rb_loc;
    logic [LOC_W-1:0]  rb_n;
    logic [WORD_W-1:0] rb_mant;
    logic [WORD_W-1:0] rb_word;
    logic              load_word;

    assign hdr_loc    = sat_loc(locationOfOne);
    assign hdr_m1     = hdr_loc - LOC_W'(1);
    assign hdr_n      = (hdr_loc <= LOC_W'(1)) ? '0 : ((hdr_m1 < MANT_N) ? hdr_m1 : MANT_N);
    assign cnt_inc    = cnt_q + LOC_W'(1);
    assign mant_shift = {mant_q[WORD_W-2:0], bitIn};

    // Feed the rebuilder with the values this cycle is about to commit, so the
    // word is ready in the same edge that enters OUT.
    assign rb_loc  = (state_q == IDLE) ? hdr_loc : loc_q;
    assign rb_n    = (state_q == IDLE) ? hdr_n   : n_q;
    assign rb_mant = (state_q == IDLE) ? '0      : mant_shift;

    word_rebuild u_word_rebuild (
        .loc_i  (rb_loc),
        .n_i    (rb_n),
        .mant_i (rb_mant),
        .word_o (rb_word)
    );

    always_comb begin
        state_d   = state_q;
        loc_d     = loc_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        mant_d    = mant_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        hdrReady  = 1'b0;
        load_word = 1'b0;

        case (state_q)
            IDLE: begin
                hdrReady = 1'b1;
                if (hdrValid) begin
                    loc_d  = hdr_loc;
                    n_d    = hdr_n;
                    cnt_d  = '0;
                    mant_d = '0;
                    err_d  = (locationOfOne > LOC_W'(WORD_W));
                    if (hdr_n == '0) begin
                        state_d   = OUT;
                        load_word = 1'b1;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (bitValid) begin
                    mant_d = mant_shift;
                    cnt_d  = cnt_inc;
                    if (cnt_inc == n_q) begin
                        state_d   = OUT;
                        load_word = 1'b1;
                    end
                end
            end
            OUT: begin
                if (outReady) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (load_word) begin
            valid_d = 1'b1;
        end
        word_d = load_word ? rb_word : word_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            loc_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            mant_q  <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            loc_q   <= loc_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            mant_q  <= mant_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign outputWord = word_q;
    assign outValid   = valid_q;
    assign hdrErr     = err_q;

endmodule

// File: tb/tb_serial_dequantizer.sv
// tb/tb_serial_dequantizer.sv - randomized self-checking bench for serial_dequantizer
module tb_serial_dequantizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  locationOfOne;
    logic        hdrValid;
    logic        hdrReady;
    logic        bitIn;
    logic        bitValid;
    logic [31:0] outputWord;
    logic        outValid;
    logic        outReady;
    logic        hdrErr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_dequantizer #(.MANT_BITS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .locationOfOne (locationOfOne),
        .hdrValid      (hdrValid),
        .hdrReady      (hdrReady),
        .bitIn         (bitIn),
        .bitValid      (bitValid),
        .outputWord    (outputWord),
        .outValid      (outValid),
        .outReady      (outReady),
        .hdrErr        (hdrErr)
    );

    function automatic int model_n(input int loc);
        int l;
        l = (loc > 32) ? 32 : loc;
        if (l <= 1) return 0;
        return (l - 1 < 8) ? l - 1 : 8;
    endfunction

    function automatic logic [31:0] model_word(input int loc, input logic [31:0] bits);
        int     l;
        int     n;
        longint m;
        longint w;
        l = (loc > 32) ? 32 : loc;
        if (l == 0) return 32'h0;
        n = model_n(loc);
        m = longint'(bits) % (longint'(2) ** n);
        w = (longint'(2) ** (l - 1)) + m * (longint'(2) ** (l - 1 - n));
        return w[31:0];
    endfunction

    task automatic send(input int loc, input logic [31:0] bits, input int gap, input int hold,
                        output logic [31:0] word, output int lat, output int errs,
                        output bit err_first, output bit stable, output bit early,
                        output bit rdy_at_hdr, output bit done_ok);
        int n;
        n = model_n(loc);
        early = 1'b0;
        @(negedge clk);
        rdy_at_hdr    = hdrReady;
        locationOfOne = 6'(loc);
        hdrValid      = 1'b1;
        @(negedge clk);
        hdrValid  = 1'b0;
        err_first = hdrErr;
        errs      = int'(hdrErr);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                if (outValid) early = 1'b1;
                bitValid = 1'b0;
                @(negedge clk);
                errs += int'(hdrErr);
            end
            if (outValid) early = 1'b1;
            bitValid = 1'b1;
            bitIn    = bits[n-1-i];
            @(negedge clk);
            bitValid = 1'b0;
            errs += int'(hdrErr);
        end
        lat = 1;
        while (!outValid && lat < 40) begin
            @(negedge clk);
            errs += int'(hdrErr);
            lat++;
        end
        word   = outputWord;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            outReady = 1'b0;
            bitValid = 1'($urandom);
            bitIn    = 1'($urandom);
            @(negedge clk);
            bitValid = 1'b0;
            errs += int'(hdrErr);
            if (outputWord !== word || outValid !== 1'b1) stable = 1'b0;
        end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        done_ok  = (outValid === 1'b0) && (hdrReady === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        locationOfOne = '0; hdrValid = 1'b0; bitIn = 1'b0; bitValid = 1'b0; outReady = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (outValid !== 1'b0 || outputWord !== 32'h0 || hdrErr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: outValid=%b outputWord=%h hdrErr=%b required 0/00000000/0",
                     outValid, outputWord, hdrErr);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (hdrReady !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hdrready: hdrReady=%b required 1", hdrReady);
        end
    endtask

    task automatic test_vectors();
        int          locs[5]  = '{32, 4, 1, 0, 40};
        logic [31:0] bitv[5]  = '{32'hB3, 32'h5, 32'h0, 32'h0, 32'hFF};
        logic [31:0] expw[5]  = '{32'hD9800000, 32'h0000000D, 32'h00000001, 32'h00000000, 32'hFF800000};
        logic [31:0] word;
        int lat, errs;
        bit err_first, stable, early, rdy, done_ok;
        for (int k = 0; k < 5; k++) begin
            send(locs[k], bitv[k], 0, 2, word, lat, errs, err_first, stable, early, rdy, done_ok);
            n_checks++;
            if (word !== expw[k]) begin
                n_fail++;
                $display("FAIL vec%0d_word: got %h required %h", k, word, expw[k]);
            end
            n_checks++;
            if (lat != 1 || early) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d early=%0d required 1 early=0", k, lat, early);
            end
            n_checks++;
            if (errs != ((locs[k] > 32) ? 1 : 0) || err_first != (locs[k] > 32)) begin
                n_fail++;
                $display("FAIL vec%0d_hdrerr: pulses=%0d first=%0d required %0d", k, errs, err_first,
                         (locs[k] > 32) ? 1 : 0);
            end
            n_checks++;
            if (!stable || !rdy || !done_ok) begin
                n_fail++;
                $display("FAIL vec%0d_handshake: stable=%0d rdy=%0d done=%0d required 1/1/1", k, stable, rdy, done_ok);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] word;
        int lat, errs;
        bit err_first, stable, early, rdy, done_ok;
        send(32, 32'hB3, 3, 5, word, lat, errs, err_first, stable, early, rdy, done_ok);
        n_checks++;
        if (word !== 32'hD9800000 || lat != 1 || early) begin
            n_fail++;
            $display("FAIL gaps_word: got %h lat=%0d early=%0d required d9800000 lat=1 early=0", word, lat, early);
        end
        n_checks++;
        if (!stable || !done_ok) begin
            n_fail++;
            $display("FAIL gaps_hold: stable=%0d single_transfer=%0d required 1/1", stable, done_ok);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] word;
        int lat, errs;
        bit err_first, stable, early, rdy, done_ok;
        bit seen;
        @(negedge clk);
        locationOfOne = 6'd32; hdrValid = 1'b1;
        @(negedge clk);
        hdrValid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bitValid = 1'b1; bitIn = 1'b1;
            @(negedge clk);
        end
        bitValid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outValid !== 1'b0 || outputWord !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_in_reset: outValid=%b outputWord=%h required 0/00000000", outValid, outputWord);
        end
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bitValid = 1'b1; bitIn = 1'b1;
            @(negedge clk);
            if (outValid !== 1'b0) seen = 1'b1;
        end
        bitValid = 1'b0;
        n_checks++;
        if (seen || hdrReady !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_no_partial: outValid_seen=%0d hdrReady=%b required 0/1", seen, hdrReady);
        end
        send(32, 32'h2C, 0, 0, word, lat, errs, err_first, stable, early, rdy, done_ok);
        n_checks++;
        if (word !== 32'h96000000 || lat != 1) begin
            n_fail++;
            $display("FAIL abort_recover: got %h lat=%0d required 96000000 lat=1", word, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] word, bits, exp;
        int loc, lat, errs;
        bit err_first, stable, early, rdy, done_ok;
        for (int k = 0; k < 30; k++) begin
            loc  = $urandom_range(0, 63);
            bits = $urandom;
            exp  = model_word(loc, bits);
            send(loc, bits, $urandom_range(0, 2), $urandom_range(0, 3),
                 word, lat, errs, err_first, stable, early, rdy, done_ok);
            n_checks++;
            if (word !== exp || lat != 1 || early) begin
                n_fail++;
                $display("FAIL rand%0d_loc%0d: got %h lat=%0d early=%0d required %h lat=1 early=0",
                         k, loc, word, lat, early, exp);
            end
            n_checks++;
            if (errs != ((loc > 32) ? 1 : 0) || !stable || !done_ok) begin
                n_fail++;
                $display("FAIL rand%0d_ctrl: hdrErr pulses=%0d stable=%0d done=%0d required %0d/1/1",
                         k, errs, stable, done_ok, (loc > 32) ? 1 : 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_pressure();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_dequantizer.md
SERIAL_DEQUANTIZER -- requirements
Module: serial_dequantizer

Interface
REQ-001 SHALL have parameter MANT_BITS, default 8: number of mantissa bits below the leading one carried serially per sample, range 1..31.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port locationOfOne, input, 6, header: 1-based leading-one position (0 = zero word, 1..32 = bit position + 1).
REQ-005 SHALL have port hdrValid, input, 1, locationOfOne valid.
REQ-006 SHALL have port hdrReady, output, 1, block accepts a header this cycle.
REQ-007 SHALL have port bitIn, input, 1, serial mantissa bit, MSB first.
REQ-008 SHALL have port bitValid, input, 1, bitIn valid; bits offered outside RECV are ignored.
REQ-009 SHALL have port outputWord, output, 32, reconstructed word.
REQ-010 SHALL have port outValid, output, 1, outputWord valid.
REQ-011 SHALL have port outReady, input, 1, downstream accepts outputWord.
REQ-012 SHALL have port hdrErr, output, 1, one-cycle pulse when an out-of-range header is accepted.

Function
REQ-013 SHALL implement FSM states IDLE, RECV, OUT.
REQ-014 IDLE: hdrReady=1; on hdrValid, latch L = min(locationOfOne, 32), set N = min(MANT_BITS, L-1) (N=0 when L<=1), clear mantissa shift register and bit counter.
REQ-015 IDLE transition: N>0 -> RECV; N=0 -> OUT directly, next cycle.
REQ-016 RECV: each cycle with bitValid=1, shift bitIn into the LSB of the mantissa register and increment the counter; bitValid=0 stalls with no state change.
REQ-017 RECV -> OUT on the cycle the N-th bit is accepted; outValid asserts the following cycle.
REQ-018 OUT: outputWord = 0 when L=0; otherwise (1 << (L-1)) | (mantissa << (L-1-N)); bits below the received mantissa are zero (truncation, no rounding).
REQ-019 outputWord and outValid SHALL be registered outputs held stable while outValid=1 and outReady=0.
REQ-020 OUT with outReady=1 -> IDLE next cycle; no header accept in the same cycle (hdrReady=0 outside IDLE).
REQ-021 Header latency: L<=1 -> outValid 1 cycle after accept; otherwise 1 cycle after the last mantissa bit.
REQ-022 locationOfOne in 33..63 SHALL saturate to 32 and pulse hdrErr for exactly one cycle, the cycle after acceptance.
REQ-023 Internal shift and shift-amount arithmetic SHALL be 32-bit unsigned; the shift amount is never negative by construction of N.

Reset
REQ-024 While rst=0: state IDLE, outputWord=0, outValid=0, hdrErr=0, mantissa and counter cleared; hdrReady=1 after release.
REQ-025 Reset asserted mid-RECV or mid-OUT SHALL abort the sample with no partial word output.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, WORD_W=32, LOC_W=6.
REQ-027 The word-assembly shift SHALL be a sub-module, word_rebuild (combinational: L, N, mantissa -> 32-bit word), registered in the top.
REQ-028 Total RTL SHALL be within 120-400 lines.

Verification
REQ-029 L=32, bits 1,0,1,1,0,0,1,1 (MANT_BITS=8) -> outputWord=0xD9800000, outValid 1 cycle after the 8th bit.
REQ-030 L=4, bits 1,0,1 -> N=3, outputWord=0x0000000D; L=1 -> 0x00000001 with no bits consumed.
REQ-031 L=0 -> outputWord=0x00000000, outValid 1 cycle after accept, bitValid pulses ignored.
REQ-032 L=40 -> hdrErr pulse, treated as L=32; all-ones bits -> 0xFF800000.
REQ-033 L=32 with bitValid gaps of 3 cycles and outReady held low 5 cycles -> same word, outputWord stable throughout, single transfer.
REQ-034 rst low after 4 of 8 bits -> outValid stays 0, next header reconstructs correctly from fresh bits.
